// File: rtl/aes_pkg.sv
// Shared AES constants: word/key widths, Rcon lookup and the inverse key schedule FSM encoding.
package aes_pkg;

   localparam int unsigned WordWidth = 32;
   localparam int unsigned KeyWidth  = 128;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StEmit = 2'd1,
      StDone = 2'd2
   } stateT;

   // Round 0 has no constant; it is never used because nothing is computed after round 0.
   function automatic logic [7:0] rcon(input logic [3:0] round);
      logic [7:0] value;
      value = 8'h00;
      unique case (round)
         4'd1:    value = 8'h01;
         4'd2:    value = 8'h02;
         4'd3:    value = 8'h04;
         4'd4:    value = 8'h08;
         4'd5:    value = 8'h10;
         4'd6:    value = 8'h20;
         4'd7:    value = 8'h40;
         4'd8:    value = 8'h80;
         4'd9:    value = 8'h1b;
         4'd10:   value = 8'h36;
         default: value = 8'h00;
      endcase
      return value;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, byte in / byte out, table packed with entry 0 at the MSBs.
module aes_sbox (
   input  logic [7:0] i_in,
   output logic [7:0] o_out
);

   localparam logic [2047:0] SboxTable = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Entry n sits at bit offset (255 - n) * 8, and 255 - n is simply ~n.
   assign o_out = SboxTable[{~i_in, 3'b000} +: 8];

endmodule

// File: rtl/aes_inv_key_schedule.sv
// Inverse AES-128 key schedule: loads the round-10 key and emits round keys 10 down to 0
// over a valid/ready handshake, deriving each predecessor combinationally from the key register.
module aes_inv_key_schedule
   import aes_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_start,
   input  logic [KeyWidth-1:0] i_lastKey,
   output logic [KeyWidth-1:0] o_roundKey,
   output logic [3:0]          o_round,
   output logic                o_keyValid,
   input  logic                i_keyReady,
   output logic                o_busy,
   output logic                o_done
);

   stateT                stateQ, stateD;
   logic [KeyWidth-1:0]  keyQ, keyD, predKey;
   logic [3:0]           roundQ, roundD;
   logic                 validQ, validD;
   logic                 busyQ, busyD;
   logic                 doneQ, doneD;
   logic                 handshake;

   logic [WordWidth-1:0] w0, w1, w2, w3;
   logic [WordWidth-1:0] w0Prev, w1Prev, w2Prev, w3Prev;
   logic [WordWidth-1:0] rotWord, subWord;

   assign {w0, w1, w2, w3} = keyQ;

   assign w3Prev  = w3 ^ w2;
   assign w2Prev  = w2 ^ w1;
   assign w1Prev  = w1 ^ w0;
   assign rotWord = {w3Prev[23:0], w3Prev[31:24]};

   for (genvar i = 0; i < 4; i++) begin : gen_subWord
      aes_sbox u_sbox (
         .i_in  (rotWord[8*i +: 8]),
         .o_out (subWord[8*i +: 8])
      );
   end

   assign w0Prev  = w0 ^ subWord ^ {rcon(roundQ), 24'h000000};
   assign predKey = {w0Prev, w1Prev, w2Prev, w3Prev};

   assign handshake = validQ & i_keyReady;

   always_comb begin
      stateD = stateQ;
      keyD   = keyQ;
      roundD = roundQ;
      unique case (stateQ)
         StIdle: begin
            if (i_start) begin
               keyD   = i_lastKey;
               roundD = 4'd10;
               stateD = StEmit;
            end
         end
         StEmit: begin
            if (handshake) begin
               if (roundQ != 4'd0) begin
                  keyD   = predKey;
                  roundD = roundQ - 4'd1;
               end else begin
                  stateD = StDone;
               end
            end
         end
         StDone:  stateD = StIdle;
         default: stateD = StIdle;
      endcase
      // Outputs are decoded from the next state so they can be registered without a cycle of lag.
      validD = (stateD == StEmit);
      busyD  = (stateD != StIdle);
      doneD  = (stateD == StDone);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         stateQ <= StIdle;
         keyQ   <= '0;
         roundQ <= 4'd0;
         validQ <= 1'b0;
         busyQ  <= 1'b0;
         doneQ  <= 1'b0;
      end else begin
         stateQ <= stateD;
         keyQ   <= keyD;
         roundQ <= roundD;
         validQ <= validD;
         busyQ  <= busyD;
         doneQ  <= doneD;
      end
   end

   assign o_roundKey = keyQ;
   assign o_round    = roundQ;
   assign o_keyValid = validQ;
   assign o_busy     = busyQ;
   assign o_done     = doneQ;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Scoreboard bench for aes_inv_key_schedule: a GF(2^8)-derived reference schedule fills a queue
// of expected round keys that a negedge monitor pops on every handshake.
module tb_aes_inv_key_schedule;

   logic         i_clk      = 1'b0;
   logic         i_rst_n    = 1'b1;
   logic         i_start    = 1'b0;
   logic [127:0] i_lastKey  = '0;
   logic         i_keyReady = 1'b0;
   logic [127:0] o_roundKey;
   logic [3:0]   o_round;
   logic         o_keyValid;
   logic         o_busy;
   logic         o_done;

   typedef struct packed {
      logic [3:0]   round;
      logic [127:0] key;
   } expT;

   localparam logic [127:0] FipsLast   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] FipsRound9 = 128'hac7766f319fadc2128d12941575c006e;
   localparam logic [127:0] FipsRound0 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   expT         expQ[$];
   int          vectors     = 0;
   int          miscompares = 0;
   int          doneCount   = 0;
   logic        expDone     = 1'b0;
   logic [31:0] w [0:43];

   aes_inv_key_schedule dut (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_start    (i_start),
      .i_lastKey  (i_lastKey),
      .o_roundKey (o_roundKey),
      .o_round    (o_round),
      .o_keyValid (o_keyValid),
      .i_keyReady (i_keyReady),
      .o_busy     (o_busy),
      .o_done     (o_done)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: field arithmetic rather than a lookup table.
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00;
      x = a;
      y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = xtime(x);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] sboxRef(input logic [7:0] x);
      logic [7:0] inv;
      inv = 8'h01;
      if (x == 8'h00) inv = 8'h00;
      else for (int i = 0; i < 254; i++) inv = gmul(inv, x);
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] rconRef(input int r);
      logic [7:0] c;
      c = 8'h01;
      for (int i = 1; i < r; i++) c = xtime(c);
      return c;
   endfunction

   function automatic logic [31:0] subWordRef(input logic [31:0] x);
      return {sboxRef(x[31:24]), sboxRef(x[23:16]), sboxRef(x[15:8]), sboxRef(x[7:0])};
   endfunction

   // Unwind the standard expansion w[i] = w[i-4] ^ temp from the last four words.
   task automatic pushRun(input logic [127:0] key);
      logic [31:0] temp;
      expT         e;
      {w[40], w[41], w[42], w[43]} = key;
      for (int i = 43; i >= 4; i--) begin
         temp = w[i-1];
         if (i % 4 == 0) temp = subWordRef({temp[23:0], temp[31:24]}) ^ {rconRef(i / 4), 24'h0};
         w[i-4] = w[i] ^ temp;
      end
      for (int r = 10; r >= 0; r--) begin
         e.round = r[3:0];
         e.key   = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
         if (key == FipsLast && r == 9) e.key = FipsRound9;
         if (key == FipsLast && r == 0) e.key = FipsRound0;
         expQ.push_back(e);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic startRun(input logic [127:0] key);
      i_lastKey = key;
      pushRun(key);
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
   endtask

   task automatic waitRound(input logic [3:0] r, input int budget);
      int n;
      n = 0;
      while ((o_round !== r || o_keyValid !== 1'b1) && n < budget) begin
         tick();
         n++;
      end
      check("round reached", {124'h0, o_round}, {124'h0, r});
   endtask

   task automatic waitDone(input int budget, input bit randomize);
      int n;
      n = 0;
      while (o_done !== 1'b1 && n < budget) begin
         if (randomize) begin
            i_keyReady = ($urandom_range(0, 3) != 0);
            i_start    = ($urandom_range(0, 7) == 0);
            i_lastKey  = {$urandom, $urandom, $urandom, $urandom};
         end
         tick();
         n++;
      end
      i_start    = 1'b0;
      i_keyReady = 1'b1;
      check("done reached", {127'h0, o_done}, 128'h1);
   endtask

   // Monitor: inputs settle after each posedge, so the negedge sees what the next edge will sample.
   initial begin
      expT e;
      forever begin
         @(negedge i_clk);
         if (!i_rst_n) begin
            expDone = 1'b0;
         end else begin
            if (o_done) doneCount++;
            if (o_done || expDone) check("done pulse", {127'h0, o_done}, {127'h0, expDone});
            expDone = 1'b0;
            if (o_keyValid && i_keyReady) begin
               if (expQ.size() == 0) begin
                  check("unexpected key", 128'h1, 128'h0);
               end else begin
                  e = expQ.pop_front();
                  check("round index", {124'h0, o_round}, {124'h0, e.round});
                  check("round key", o_roundKey, e.key);
                  if (e.round == 4'd0) expDone = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      logic [127:0] keyA, keyB;
      int           dc;

      // Reset values
      #1 i_rst_n = 1'b0;
      #2;
      check("reset roundKey", o_roundKey, 128'h0);
      check("reset round", {124'h0, o_round}, 128'h0);
      check("reset valid", {127'h0, o_keyValid}, 128'h0);
      check("reset busy", {127'h0, o_busy}, 128'h0);
      check("reset done", {127'h0, o_done}, 128'h0);
      tick();
      i_rst_n = 1'b1;
      tick();

      // 1: FIPS-197 key, ready held high, 11 consecutive keys then done
      i_keyReady = 1'b1;
      startRun(FipsLast);
      check("busy after start", {127'h0, o_busy}, 128'h1);
      for (int i = 10; i >= 0; i--) begin
         check("valid streak", {127'h0, o_keyValid}, 128'h1);
         check("streak round", {124'h0, o_round}, {124'h0, i[3:0]});
         tick();
      end
      check("done after round 0", {127'h0, o_done}, 128'h1);
      check("busy in done cycle", {127'h0, o_busy}, 128'h1);
      check("valid low in done", {127'h0, o_keyValid}, 128'h0);
      tick();
      check("busy after done", {127'h0, o_busy}, 128'h0);

      // 2: backpressure at round 7
      startRun(FipsLast);
      waitRound(4'd7, 20);
      i_keyReady = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall valid", {127'h0, o_keyValid}, 128'h1);
         check("stall round", {124'h0, o_round}, 128'h7);
         if (expQ.size() > 0) check("stall key", o_roundKey, expQ[0].key);
      end
      i_keyReady = 1'b1;
      waitDone(40, 1'b0);
      tick();

      // 3: start while busy is ignored
      startRun(FipsLast);
      waitRound(4'd5, 20);
      i_lastKey = {$urandom, $urandom, $urandom, $urandom};
      i_start   = 1'b1;
      tick();
      i_start = 1'b0;
      waitDone(40, 1'b0);
      tick();

      // 4: asynchronous reset mid-run
      startRun(FipsLast);
      waitRound(4'd4, 20);
      dc = doneCount;
      #2 i_rst_n = 1'b0;
      #1;
      check("midrun reset key", o_roundKey, 128'h0);
      check("midrun reset round", {124'h0, o_round}, 128'h0);
      check("midrun reset valid", {127'h0, o_keyValid}, 128'h0);
      check("midrun reset busy", {127'h0, o_busy}, 128'h0);
      check("midrun reset done", {127'h0, o_done}, 128'h0);
      expQ.delete();
      tick();
      i_rst_n = 1'b1;
      repeat (4) tick();
      check("no done after reset", dc, doneCount);
      startRun(FipsLast);
      waitDone(40, 1'b0);
      tick();

      // 5: all-zero key with random backpressure
      dc = doneCount;
      startRun(128'h0);
      waitDone(300, 1'b1);
      repeat (4) tick();
      check("zero key done once", doneCount - dc, 1);

      // 6: back-to-back with start held high
      keyA = {$urandom, $urandom, $urandom, $urandom};
      keyB = {$urandom, $urandom, $urandom, $urandom};
      i_lastKey = keyA;
      pushRun(keyA);
      i_start = 1'b1;
      tick();
      i_lastKey = keyB;
      pushRun(keyB);
      waitDone(40, 1'b0);
      i_start = 1'b1;
      tick();
      check("b2b gap valid", {127'h0, o_keyValid}, 128'h0);
      check("b2b done width", {127'h0, o_done}, 128'h0);
      tick();
      i_start = 1'b0;
      check("b2b restart valid", {127'h0, o_keyValid}, 128'h1);
      check("b2b restart round", {124'h0, o_round}, 128'ha);
      waitDone(40, 1'b0);
      tick();

      // Random keys with random backpressure and stray starts
      for (int k = 0; k < 4; k++) begin
         startRun({$urandom, $urandom, $urandom, $urandom});
         waitDone(300, 1'b1);
         repeat (2) tick();
      end

      check("queue drained", expQ.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
